// File: rtl/vga_rect_fill.sv
// Rectangle fill engine: clips a corner-pair command to the visible area and issues one
// 8-bit Avalon-MM pixel write per covered pixel. Optional abort input under RECT_FILL_ABORT_EN.
module vga_rect_fill #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic        clk,
    input  logic        reset,
`ifdef RECT_FILL_ABORT_EN
    input  logic        abort,
`endif
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_x0,
    input  logic [9:0]  cmd_x1,
    input  logic [9:0]  cmd_y0,
    input  logic [9:0]  cmd_y1,
    input  logic [7:0]  cmd_colour,
    output logic [19:0] m_address,
    output logic        m_chipselect,
    output logic        m_write,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest,
    output logic        busy,
    output logic        done,
    output logic [18:0] pix_count
);
    localparam logic [10:0] H_LIM    = 11'(H_RES);
    localparam logic [10:0] V_LIM    = 11'(V_RES);
    localparam logic [9:0]  X_LAST   = 10'(H_RES - 1);
    localparam logic [9:0]  Y_LAST   = 10'(V_RES - 1);
    localparam logic [18:0] ROW_STEP = 19'(H_RES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [9:0]  x0_reg, x0_next, x1_reg, x1_next;
    logic [9:0]  y0_reg, y0_next, y1_reg, y1_next;
    logic [7:0]  colour_reg, colour_next;
    logic [9:0]  x_reg, x_next, y_reg, y_next;
    logic [9:0]  xmin_reg, xmin_next, xmax_reg, xmax_next, ymax_reg, ymax_next;
    logic [18:0] row_base_reg, row_base_next;
    logic [18:0] addr_reg, addr_next;
    logic [18:0] pix_count_reg, pix_count_next;
    logic        abort_pend_reg, abort_pend_next;
    logic        abort_in;

`ifdef RECT_FILL_ABORT_EN
    assign abort_in = abort;
`else
    assign abort_in = 1'b0;
`endif

    // Corner ordering and clipping of the captured command, used during SETUP.
    logic [9:0] sx_lo, sx_hi, sy_lo, sy_hi, sx_max, sy_max;
    logic       rect_empty;

    assign sx_lo      = (x0_reg < x1_reg) ? x0_reg : x1_reg;
    assign sx_hi      = (x0_reg < x1_reg) ? x1_reg : x0_reg;
    assign sy_lo      = (y0_reg < y1_reg) ? y0_reg : y1_reg;
    assign sy_hi      = (y0_reg < y1_reg) ? y1_reg : y0_reg;
    assign sx_max     = (sx_hi > X_LAST) ? X_LAST : sx_hi;
    assign sy_max     = (sy_hi > Y_LAST) ? Y_LAST : sy_hi;
    assign rect_empty = ({1'b0, sx_lo} >= H_LIM) || ({1'b0, sy_lo} >= V_LIM);

    // ymin * H_RES as a chain of constant shift-adds; zero bits of H_RES collapse away.
    logic [18:0]        ymin_w;
    logic [10:0][18:0]  pp_sum;
    logic [18:0]        row_base_calc;

    assign ymin_w    = {9'b0, sy_lo};
    assign pp_sum[0] = '0;

    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_row_mul
            if (ROW_STEP[gi]) begin : g_add
                assign pp_sum[gi+1] = pp_sum[gi] + (ymin_w << gi);
            end else begin : g_skip
                assign pp_sum[gi+1] = pp_sum[gi];
            end
        end
    endgenerate

    assign row_base_calc = pp_sum[10];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            x0_reg         <= '0;
            x1_reg         <= '0;
            y0_reg         <= '0;
            y1_reg         <= '0;
            colour_reg     <= '0;
            x_reg          <= '0;
            y_reg          <= '0;
            xmin_reg       <= '0;
            xmax_reg       <= '0;
            ymax_reg       <= '0;
            row_base_reg   <= '0;
            addr_reg       <= '0;
            pix_count_reg  <= '0;
            abort_pend_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            x0_reg         <= x0_next;
            x1_reg         <= x1_next;
            y0_reg         <= y0_next;
            y1_reg         <= y1_next;
            colour_reg     <= colour_next;
            x_reg          <= x_next;
            y_reg          <= y_next;
            xmin_reg       <= xmin_next;
            xmax_reg       <= xmax_next;
            ymax_reg       <= ymax_next;
            row_base_reg   <= row_base_next;
            addr_reg       <= addr_next;
            pix_count_reg  <= pix_count_next;
            abort_pend_reg <= abort_pend_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        x0_next         = x0_reg;
        x1_next         = x1_reg;
        y0_next         = y0_reg;
        y1_next         = y1_reg;
        colour_next     = colour_reg;
        x_next          = x_reg;
        y_next          = y_reg;
        xmin_next       = xmin_reg;
        xmax_next       = xmax_reg;
        ymax_next       = ymax_reg;
        row_base_next   = row_base_reg;
        addr_next       = addr_reg;
        pix_count_next  = pix_count_reg;
        abort_pend_next = abort_pend_reg;

        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    x0_next         = cmd_x0;
                    x1_next         = cmd_x1;
                    y0_next         = cmd_y0;
                    y1_next         = cmd_y1;
                    colour_next     = cmd_colour;
                    pix_count_next  = '0;
                    abort_pend_next = 1'b0;
                    state_next      = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (rect_empty || abort_in) begin
                    state_next = ST_DONE;
                end else begin
                    xmin_next     = sx_lo;
                    xmax_next     = sx_max;
                    ymax_next     = sy_max;
                    x_next        = sx_lo;
                    y_next        = sy_lo;
                    row_base_next = row_base_calc;
                    addr_next     = row_base_calc + {9'b0, sx_lo};
                    state_next    = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (abort_in) begin
                    abort_pend_next = 1'b1;
                end
                // Everything advances only on an accepted write; a stall holds the bus.
                if (!m_waitrequest) begin
                    pix_count_next = pix_count_reg + 19'd1;
                    if (abort_in || abort_pend_reg) begin
                        state_next = ST_DONE;
                    end else if (x_reg < xmax_reg) begin
                        x_next    = x_reg + 10'd1;
                        addr_next = addr_reg + 19'd1;
                    end else if (y_reg < ymax_reg) begin
                        x_next        = xmin_reg;
                        y_next        = y_reg + 10'd1;
                        row_base_next = row_base_reg + ROW_STEP;
                        addr_next     = row_base_reg + ROW_STEP + {9'b0, xmin_reg};
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready    = (state_reg == ST_IDLE);
    assign m_write      = (state_reg == ST_WRITE);
    assign m_chipselect = (state_reg == ST_WRITE);
    assign m_address    = {1'b0, addr_reg};
    assign m_writedata  = {24'b0, colour_reg};
    assign busy         = (state_reg != ST_IDLE);
    assign done         = (state_reg == ST_DONE);
    assign pix_count    = pix_count_reg;

endmodule
